// File: rtl/whitening_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | whitening_pkg : shared state encoding, unit-enable bundle and helpers     |
// | for the FastICA whitening sequencer.                       Rev 1.0        |
// +--------------------------------------------------------------------------+
package whitening_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_LOAD      = 4'd1,
    ST_CEN_DRAIN = 4'd2,
    ST_COV       = 4'd3,
    ST_QR_ARM    = 4'd4,
    ST_QR_RUN    = 4'd5,
    ST_MULT1     = 4'd6,
    ST_MULT2     = 4'd7,
    ST_DONE      = 4'd8,
    ST_ERR       = 4'd9
  } state_e;

  typedef struct packed {
    logic busy;
    logic done;
    logic err;
    logic en_mem1;
    logic go_cen;
    logic en_mem2;
    logic go_cov;
    logic go_qr;
    logic en_multi_1;
    logic en_multi_2;
    logic en_mem3;
  } ctrl_t;

  // Counter width must hold the longest timed state length minus one.
  function automatic int calc_cnt_w(input int n_samples, input int n_ch, input int qr_timeout);
    int m;
    m = n_samples;
    if (n_ch * n_ch > m) m = n_ch * n_ch;
    if (qr_timeout > m) m = qr_timeout;
    return $clog2(m) + 1;
  endfunction

  function automatic ctrl_t decode_ctrl(input state_e st);
    ctrl_t c;
    c      = '0;
    c.busy = (st != ST_IDLE) && (st != ST_ERR);
    case (st)
      ST_LOAD: begin
        c.en_mem1 = 1'b1;
        c.go_cen  = 1'b1;
      end
      ST_CEN_DRAIN: c.go_cen = 1'b1;
      ST_COV: begin
        c.go_cen  = 1'b1;
        c.go_cov  = 1'b1;
        c.en_mem2 = 1'b1;
      end
      ST_QR_ARM: begin
        c.go_cov = 1'b1;
        c.go_qr  = 1'b1;
      end
      ST_QR_RUN: c.go_qr = 1'b1;
      ST_MULT1:  c.en_multi_1 = 1'b1;
      ST_MULT2: begin
        c.en_multi_2 = 1'b1;
        c.en_mem3    = 1'b1;
      end
      ST_DONE: c.done = 1'b1;
      ST_ERR:  c.err  = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/whitening_stage_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | whitening_stage_timer : per-state cycle counter with terminal-count       |
// | strobe against the current state's length or QR timeout.   Rev 1.0        |
// +--------------------------------------------------------------------------+
module whitening_stage_timer
  import whitening_pkg::*;
#(
  parameter int N_SAMPLES  = 128,
  parameter int N_CH       = 4,
  parameter int CEN_LAT    = 1,
  parameter int QR_TIMEOUT = 1024,
  parameter int CNT_W      = 11
) (
  input  logic   clk,
  input  logic   rst,
  input  state_e state_i,
  input  logic   state_chg_i,
  output logic   tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] len_m1;
  logic             timed;

  always_comb begin
    len_m1 = '0;
    timed  = 1'b1;
    case (state_i)
      ST_LOAD, ST_COV, ST_MULT2: len_m1 = CNT_W'(N_SAMPLES - 1);
      ST_CEN_DRAIN:              len_m1 = CNT_W'(CEN_LAT - 1);
      ST_QR_ARM, ST_QR_RUN:      len_m1 = CNT_W'(QR_TIMEOUT - 1);
      ST_MULT1:                  len_m1 = CNT_W'(N_CH * N_CH - 1);
      default:                   timed  = 1'b0;
    endcase
  end

  // Untimed states park the counter at zero so it can never wrap while idle.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (state_chg_i || !timed) cnt_d = '0;
  end

  assign tc_o = timed && (cnt_q == len_m1);

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/whitening_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | whitening_sequencer : control FSM sequencing load, centring, covariance,  |
// | QR handshake and the two whitening multiplies.             Rev 1.0        |
// +--------------------------------------------------------------------------+
module whitening_sequencer
  import whitening_pkg::*;
#(
  parameter int N_SAMPLES  = 128,
  parameter int N_CH       = 4,
  parameter int CEN_LAT    = 1,
  parameter int QR_TIMEOUT = 1024,
  parameter bit MODE_CONT  = 1'b0
) (
  input  logic       CLK_Whitening,
  input  logic       RST_Whitening,
  input  logic       GO_whitening,
  input  logic       New_one,
  input  logic       QR_busy,
  output logic       Whitening_busy,
  output logic       Whitening_done,
  output logic       Whitening_err,
  output logic [3:0] stage_o,
  output logic       En_mem1,
  output logic       GO_cen,
  output logic       En_mem2,
  output logic       GO_cov,
  output logic       GO_QR,
  output logic       En_multi_1,
  output logic       En_multi_2,
  output logic       En_mem3
);

  localparam int CNT_W = calc_cnt_w(N_SAMPLES, N_CH, QR_TIMEOUT);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl_q;
  ctrl_t  ctrl_d;
  logic   tc;
  logic   state_chg;

  whitening_stage_timer #(
    .N_SAMPLES  (N_SAMPLES),
    .N_CH       (N_CH),
    .CEN_LAT    (CEN_LAT),
    .QR_TIMEOUT (QR_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk         (CLK_Whitening),
    .rst         (RST_Whitening),
    .state_i     (state_q),
    .state_chg_i (state_chg),
    .tc_o        (tc)
  );

  // Handshake events are tested before the timeout so a late handshake wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (GO_whitening) state_d = ST_LOAD;
      ST_LOAD:      if (tc) state_d = ST_CEN_DRAIN;
      ST_CEN_DRAIN: if (tc) state_d = ST_COV;
      ST_COV:       if (tc) state_d = ST_QR_ARM;
      ST_QR_ARM: begin
        if (QR_busy)  state_d = ST_QR_RUN;
        else if (tc)  state_d = ST_ERR;
      end
      ST_QR_RUN: begin
        if (!QR_busy) state_d = ST_MULT1;
        else if (tc)  state_d = ST_ERR;
      end
      ST_MULT1:     if (tc) state_d = ST_MULT2;
      ST_MULT2:     if (tc) state_d = ST_DONE;
      ST_DONE:      state_d = (MODE_CONT && New_one) ? ST_LOAD : ST_IDLE;
      ST_ERR:       if (GO_whitening) state_d = ST_LOAD;
      default:      state_d = ST_IDLE;
    endcase
  end

  assign state_chg = (state_d != state_q);

  // Outputs are registered from the next state so they align with the state.
  always_comb begin
    ctrl_d = decode_ctrl(state_d);
  end

  always_ff @(posedge CLK_Whitening) begin
    if (RST_Whitening) begin
      state_q <= ST_IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign stage_o        = state_q;
  assign Whitening_busy = ctrl_q.busy;
  assign Whitening_done = ctrl_q.done;
  assign Whitening_err  = ctrl_q.err;
  assign En_mem1        = ctrl_q.en_mem1;
  assign GO_cen         = ctrl_q.go_cen;
  assign En_mem2        = ctrl_q.en_mem2;
  assign GO_cov         = ctrl_q.go_cov;
  assign GO_QR          = ctrl_q.go_qr;
  assign En_multi_1     = ctrl_q.en_multi_1;
  assign En_multi_2     = ctrl_q.en_multi_2;
  assign En_mem3        = ctrl_q.en_mem3;

endmodule
`default_nettype wire

// File: tb/tb_whitening_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_whitening_sequencer : directed self-checking bench for the whitening  |
// | sequencer (single-shot and continuous-mode instances).     Rev 1.0        |
// +--------------------------------------------------------------------------+
module tb_whitening_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic go = 1'b0, new_one = 1'b0, qr_busy = 1'b0;
  logic go_c = 1'b0, qr_busy_c = 1'b0;

  logic busy, done, err, en_mem1, go_cen, en_mem2, go_cov, go_qr, en_m1, en_m2, en_mem3;
  logic [3:0] stage;
  logic busy_c, done_c, err_c, en_mem1_c, go_cen_c, en_mem2_c, go_cov_c, go_qr_c;
  logic en_m1_c, en_m2_c, en_mem3_c;
  logic [3:0] stage_c;

  logic [10:0] outs;
  logic [7:0]  ens;
  logic [10:0] outs_c;
  assign outs   = {busy, done, err, en_mem1, go_cen, en_mem2, go_cov, go_qr, en_m1, en_m2, en_mem3};
  assign ens    = {en_mem1, go_cen, en_mem2, go_cov, go_qr, en_m1, en_m2, en_mem3};
  assign outs_c = {busy_c, done_c, err_c, en_mem1_c, go_cen_c, en_mem2_c, go_cov_c, go_qr_c,
                   en_m1_c, en_m2_c, en_mem3_c};

  int errors = 0;
  int checks = 0;
  int n;
  int cnt_a [13] = '{default: 0};
  int base  [13];

  always #5 clk = ~clk;

  whitening_sequencer #(
    .N_SAMPLES(8), .N_CH(2), .CEN_LAT(2), .QR_TIMEOUT(16), .MODE_CONT(1'b0)
  ) dut (
    .CLK_Whitening(clk), .RST_Whitening(rst), .GO_whitening(go), .New_one(new_one),
    .QR_busy(qr_busy), .Whitening_busy(busy), .Whitening_done(done), .Whitening_err(err),
    .stage_o(stage), .En_mem1(en_mem1), .GO_cen(go_cen), .En_mem2(en_mem2), .GO_cov(go_cov),
    .GO_QR(go_qr), .En_multi_1(en_m1), .En_multi_2(en_m2), .En_mem3(en_mem3)
  );

  whitening_sequencer #(
    .N_SAMPLES(8), .N_CH(2), .CEN_LAT(2), .QR_TIMEOUT(16), .MODE_CONT(1'b1)
  ) dut_c (
    .CLK_Whitening(clk), .RST_Whitening(rst), .GO_whitening(go_c), .New_one(new_one),
    .QR_busy(qr_busy_c), .Whitening_busy(busy_c), .Whitening_done(done_c), .Whitening_err(err_c),
    .stage_o(stage_c), .En_mem1(en_mem1_c), .GO_cen(go_cen_c), .En_mem2(en_mem2_c),
    .GO_cov(go_cov_c), .GO_QR(go_qr_c), .En_multi_1(en_m1_c), .En_multi_2(en_m2_c),
    .En_mem3(en_mem3_c)
  );

  // Per-cycle high counts, sampled mid-cycle.
  always @(negedge clk) begin
    if (en_mem1)     cnt_a[0]++;
    if (stage == 4'd2) cnt_a[1]++;
    if (go_cen)      cnt_a[2]++;
    if (en_mem2)     cnt_a[3]++;
    if (go_cov)      cnt_a[4]++;
    if (go_qr)       cnt_a[5]++;
    if (en_m1)       cnt_a[6]++;
    if (en_m2)       cnt_a[7]++;
    if (en_mem3)     cnt_a[8]++;
    if (done)        cnt_a[9]++;
    if (busy)        cnt_a[10]++;
    if (done_c)      cnt_a[11]++;
    if (busy_c)      cnt_a[12]++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_stage(input bit sel, input logic [3:0] tgt, input string tag);
    int i = 0;
    while ((sel ? stage_c : stage) !== tgt && i < 200) begin
      @(negedge clk);
      i++;
    end
    check(tag, {28'd0, (sel ? stage_c : stage)}, {28'd0, tgt});
  endtask

  initial begin
    // Reset state
    tick(2);
    check("rst_stage", {28'd0, stage}, 32'd0);
    check("rst_outs", {21'd0, outs}, 32'd0);
    check("rst_outs_c", {21'd0, outs_c, stage_c}, 32'd0);
    rst = 1'b0;
    tick(1);

    // 1: nominal run, ARM 2 cycles, RUN 5 cycles
    base = cnt_a;
    go = 1'b1; tick(1); go = 1'b0;
    check("t1_load", {28'd0, stage}, 32'd1);
    wait_stage(1'b0, 4'd4, "t1_arm");
    tick(1); qr_busy = 1'b1; tick(1);
    check("t1_run", {28'd0, stage}, 32'd5);
    tick(4); qr_busy = 1'b0;
    wait_stage(1'b0, 4'd8, "t1_done_state");
    check("t1_done_pulse", {31'd0, done}, 32'd1);
    tick(1);
    check("t1_idle", {28'd0, stage}, 32'd0);
    check("t1_idle_outs", {21'd0, outs}, 32'd0);
    check("t1_mem1", cnt_a[0] - base[0], 32'd8);
    check("t1_drain", cnt_a[1] - base[1], 32'd2);
    check("t1_go_cen", cnt_a[2] - base[2], 32'd18);
    check("t1_mem2", cnt_a[3] - base[3], 32'd8);
    check("t1_go_cov", cnt_a[4] - base[4], 32'd10);
    check("t1_go_qr", cnt_a[5] - base[5], 32'd7);
    check("t1_multi1", cnt_a[6] - base[6], 32'd4);
    check("t1_multi2", cnt_a[7] - base[7], 32'd8);
    check("t1_mem3", cnt_a[8] - base[8], 32'd8);
    check("t1_done_cnt", cnt_a[9] - base[9], 32'd1);
    check("t1_busy_cnt", cnt_a[10] - base[10], 32'd38);

    // 2: QR never starts -> 16 cycles in ARM then ERR
    go = 1'b1; tick(1); go = 1'b0;
    wait_stage(1'b0, 4'd4, "t2_arm");
    n = 0;
    while (stage == 4'd4 && n < 40) begin n++; tick(1); end
    check("t2_arm_cycles", n, 32'd16);
    check("t2_err_state", {28'd0, stage}, 32'd9);
    check("t2_err_flag", {31'd0, err}, 32'd1);
    check("t2_busy", {31'd0, busy}, 32'd0);
    check("t2_enables", {24'd0, ens}, 32'd0);
    tick(3);
    check("t2_err_sticky", {27'd0, err, stage}, {27'd0, 1'b1, 4'd9});
    go = 1'b1; tick(1); go = 1'b0;
    check("t2_relaunch", {26'd0, err, busy, stage}, {26'd0, 1'b0, 1'b1, 4'd1});

    // 3a: QR_busy already high at ARM entry, then stuck -> 16 cycles in RUN
    wait_stage(1'b0, 4'd4, "t3a_arm");
    qr_busy = 1'b1; tick(1);
    check("t3a_prearmed_run", {28'd0, stage}, 32'd5);
    n = 0;
    while (stage == 4'd5 && n < 40) begin n++; tick(1); end
    check("t3a_run_cycles", n, 32'd16);
    check("t3a_err", {27'd0, err, stage}, {27'd0, 1'b1, 4'd9});
    qr_busy = 1'b0;

    // 3b: QR finishes on the last allowed cycle
    go = 1'b1; tick(1); go = 1'b0;
    wait_stage(1'b0, 4'd4, "t3b_arm");
    qr_busy = 1'b1; tick(1); tick(15);
    check("t3b_still_run", {28'd0, stage}, 32'd5);
    qr_busy = 1'b0; tick(1);
    check("t3b_mult1_no_err", {27'd0, err, stage}, {27'd0, 1'b0, 4'd6});
    wait_stage(1'b0, 4'd0, "t3b_idle");

    // 3c: one-cycle QR_busy pulse counts as completion
    go = 1'b1; tick(1); go = 1'b0;
    wait_stage(1'b0, 4'd4, "t3c_arm");
    qr_busy = 1'b1; tick(1); qr_busy = 1'b0;
    check("t3c_run", {28'd0, stage}, 32'd5);
    tick(1);
    check("t3c_mult1", {28'd0, stage}, 32'd6);
    wait_stage(1'b0, 4'd0, "t3c_idle");

    // 4: reset mid-COV with GO held high
    go = 1'b1; tick(1); go = 1'b0;
    wait_stage(1'b0, 4'd3, "t4_cov");
    tick(3);
    check("t4_cov_cnt3", {28'd0, stage}, 32'd3);
    rst = 1'b1; go = 1'b1; tick(1);
    check("t4_rst_all", {17'd0, outs, stage}, 32'd0);
    tick(1);
    check("t4_rst_hold", {17'd0, outs, stage}, 32'd0);
    rst = 1'b0; tick(1);
    check("t4_go_after_rst", {28'd0, stage}, 32'd1);
    go = 1'b0; rst = 1'b1; tick(1); rst = 1'b0;

    // 6: GO toggling in LOAD and MULT2 has no effect; GO/New_one ignored in DONE
    base = cnt_a;
    go = 1'b1; tick(1);
    repeat (5) begin go = ~go; tick(1); end
    go = 1'b0;
    wait_stage(1'b0, 4'd4, "t6_arm");
    qr_busy = 1'b1; tick(1); qr_busy = 1'b0;
    wait_stage(1'b0, 4'd7, "t6_mult2");
    repeat (4) begin go = ~go; tick(1); end
    go = 1'b0;
    wait_stage(1'b0, 4'd8, "t6_done");
    go = 1'b1; new_one = 1'b1; tick(1);
    check("t6_done_to_idle", {28'd0, stage}, 32'd0);
    go = 1'b0; new_one = 1'b0; tick(1);
    check("t6_idle_stays", {28'd0, stage}, 32'd0);
    check("t6_mem1", cnt_a[0] - base[0], 32'd8);
    check("t6_multi1", cnt_a[6] - base[6], 32'd4);
    check("t6_multi2", cnt_a[7] - base[7], 32'd8);
    check("t6_go_qr", cnt_a[5] - base[5], 32'd2);
    check("t6_done_cnt", cnt_a[9] - base[9], 32'd1);

    // 5: continuous mode, two batches back to back
    base = cnt_a;
    go_c = 1'b1; tick(1); go_c = 1'b0;
    wait_stage(1'b1, 4'd4, "t5_arm1");
    qr_busy_c = 1'b1; tick(1); qr_busy_c = 1'b0;
    wait_stage(1'b1, 4'd8, "t5_done1");
    check("t5_done1_pulse", {31'd0, done_c}, 32'd1);
    new_one = 1'b1; tick(1); new_one = 1'b0;
    check("t5_reload", {26'd0, done_c, busy_c, stage_c}, {26'd0, 1'b0, 1'b1, 4'd1});
    wait_stage(1'b1, 4'd4, "t5_arm2");
    qr_busy_c = 1'b1; tick(1); qr_busy_c = 1'b0;
    wait_stage(1'b1, 4'd8, "t5_done2");
    tick(1);
    check("t5_idle", {28'd0, stage_c}, 32'd0);
    check("t5_done_cnt", cnt_a[11] - base[11], 32'd2);
    check("t5_busy_cnt", cnt_a[12] - base[12], 32'd66);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
